spi_shifter: RTL and testbench



---
 rtl/spi_shifter.sv | 163 ++++++++++++++++
 tb/tb_spi_shifter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_shifter.sv
// SPI mode-3 frame engine: one 16-bit transaction per req/ack handshake.
// Returns the byte clocked in during the second half of the frame.
module spi_shifter #(
  parameter int CLK_DIV = 25
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [15:0] pachet_i,
  output logic        ack_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        spi_cs_n_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_GAP      = 3'd4,
    ST_ACK      = 3'd5,
    ST_WAIT_LOW = 3'd6
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          phase_r;
  logic [3:0]    bit_r;
  logic [15:0]   tx_r;
  logic [7:0]    rx_r;
  logic          ack_r;
  logic [7:0]    data_r;
  logic          busy_r;
  logic          cs_n_r;
  logic          sclk_r;
  logic          mosi_r;
  logic          cnt_done_s;
  logic          cs_active_s;

  assign cnt_done_s  = (cnt_r == CNT_LAST);
  assign cs_active_s = (state_r == ST_SETUP) || (state_r == ST_SHIFT) || (state_r == ST_HOLD);

  assign ack_o      = ack_r;
  assign data_o     = data_r;
  assign busy_o     = busy_r;
  assign spi_cs_n_o = cs_n_r;
  assign spi_sclk_o = sclk_r;
  assign spi_mosi_o = mosi_r;

  // Frame FSM; pins are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      phase_r <= 1'b0;
      bit_r   <= 4'd0;
      tx_r    <= 16'h0000;
      rx_r    <= 8'h00;
      ack_r   <= 1'b0;
      data_r  <= 8'h00;
      busy_r  <= 1'b0;
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b1;
      mosi_r  <= 1'b0;
    end else begin
      ack_r  <= (state_r == ST_ACK);
      busy_r <= (state_r != ST_IDLE);
      cs_n_r <= !cs_active_s;
      sclk_r <= !((state_r == ST_SHIFT) && !phase_r);
      mosi_r <= cs_active_s ? tx_r[15] : 1'b0;
      if (state_r == ST_ACK) begin
        data_r <= rx_r;
      end else begin
        data_r <= data_r;
      end

      case (state_r)
        ST_IDLE: begin
          cnt_r   <= '0;
          phase_r <= 1'b0;
          bit_r   <= 4'd0;
          if (req_i) begin
            tx_r    <= pachet_i;
            rx_r    <= 8'h00;
            state_r <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt_done_s) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
            state_r <= ST_SHIFT;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_SHIFT: begin
          // First cycle of the high half is the edge that raises SCLK on the pin.
          if (phase_r && (cnt_r == '0)) begin
            rx_r <= {rx_r[6:0], spi_miso_i};
          end else begin
            rx_r <= rx_r;
          end
          if (!cnt_done_s) begin
            cnt_r <= cnt_r + CW'(1);
          end else if (!phase_r) begin
            cnt_r   <= '0;
            phase_r <= 1'b1;
          end else begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
            tx_r    <= {tx_r[14:0], 1'b0};
            if (bit_r == 4'd15) begin
              bit_r   <= 4'd0;
              state_r <= ST_HOLD;
            end else begin
              bit_r <= bit_r + 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_done_s) begin
            cnt_r   <= '0;
            state_r <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_done_s) begin
            cnt_r   <= '0;
            state_r <= ST_ACK;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_ACK: begin
          state_r <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!req_i) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_LOW;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shifter.sv
// Scoreboard bench for spi_shifter: stimulus queues expected frames, a pin-level
// monitor reconstructs each frame and checks it when ack_o fires.
module tb_spi_shifter;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [15:0] pachet = 16'h0000;
  logic        ack;
  logic [7:0]  data;
  logic        busy;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] tx;
    logic [7:0]  rx;
    int          start;
  } exp_t;
  exp_t sb_q[$];

  logic [15:0] slave_word = 16'hFFFF;
  logic [7:0]  last_rx = 8'h00;

  spi_shifter #(.CLK_DIV(DIV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .pachet_i(pachet),
    .ack_o(ack), .data_o(data), .busy_o(busy),
    .spi_cs_n_o(cs_n), .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Slave: mode 3 puts the next reply bit on MISO at every falling SCLK.
  logic sl_prev = 1'b1;
  int   sl_bit = 0;
  always @(negedge clk) begin
    if (cs_n) begin
      sl_bit = 0;
    end else if (sl_prev && !sclk && sl_bit < 16) begin
      miso = slave_word[15 - sl_bit];
      sl_bit++;
    end
    sl_prev = sclk;
  end

  // Monitor: collect MOSI at rising SCLK, time CS, check each ack against the queue.
  logic [15:0] cap = 16'h0000;
  int ncap = 0, cs_low = 0, cs_high = 1000;
  logic m_prev_sclk = 1'b1, m_prev_cs = 1'b1, m_prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ncap = 0; cs_low = 0; cs_high = 1000;
    end else begin
      if (!cs_n && m_prev_cs) begin
        if (cs_high < DIV) chk("cs_gap", cs_high, DIV);
        ncap = 0; cs_low = 0;
      end
      if (!cs_n) begin
        cs_low++; cs_high = 0;
        if (!m_prev_sclk && sclk) begin
          cap = {cap[14:0], mosi};
          ncap++;
        end
      end else begin
        cs_high++;
      end
      if (ack) begin
        if (m_prev_ack) chk("ack_width", 2, 1);
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("mosi_bit_count", ncap, 16);
          chk("mosi_bits", cap, e.tx);
          chk("data_o", data, e.rx);
          chk("ack_cycle", cyc - e.start, 35 * DIV + 1);
          chk("cs_low_cycles", cs_low, 34 * DIV);
        end
      end
    end
    m_prev_sclk = sclk; m_prev_cs = cs_n; m_prev_ack = ack;
  end

  task automatic check_idle(input string nm);
    chk({nm, "_cs_n"}, cs_n, 1);
    chk({nm, "_sclk"}, sclk, 1);
    chk({nm, "_mosi"}, mosi, 0);
    chk({nm, "_ack"}, ack, 0);
    chk({nm, "_data"}, data, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic wait_ack();
    bit seen = 0;
    for (int i = 0; i < 40 * DIV + 50; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1;
        break;
      end
    end
    chk("ack_seen", seen, 1);
  endtask

  task automatic run_frame(input logic [15:0] word, input logic [15:0] reply,
                           input int drop_at, input int hold_after);
    exp_t e;
    @(negedge clk);
    pachet = word; slave_word = reply; req = 1'b1;
    e.tx = word; e.rx = reply[7:0]; e.start = cyc + 1;
    sb_q.push_back(e);
    last_rx = reply[7:0];
    if (drop_at > 0) begin
      repeat (drop_at) @(negedge clk);
      pachet = 16'hFFFF; req = 1'b0;
    end
    wait_ack();
    chk("busy_after_ack", busy, 1);
    for (int i = 0; i < hold_after; i++) begin
      @(negedge clk);
      chk("no_restart_cs", cs_n, 1);
    end
    req = 1'b0;
    pachet = 16'($urandom);
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(16'h310C, 16'hFFFF, 0, 0);
    run_frame(16'hB300, 16'hC35A, 0, 0);
    run_frame(16'($urandom), 16'($urandom), 0, 20);
    run_frame(16'h2D08, 16'($urandom), 1 + DIV + 4 * 2 * DIV, 0);

    // Reset during bit 7; the partial frame must vanish without an ack.
    @(negedge clk);
    pachet = 16'h0F0F; slave_word = 16'hAAAA; req = 1'b1;
    repeat (1 + DIV + 7 * 2 * DIV) @(negedge clk);
    chk("mid_frame_cs_low", cs_n, 0);
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rst_next_cs_n", cs_n, 1);
    chk("rst_next_sclk", sclk, 1);
    repeat (2) @(negedge clk);
    check_idle("mid_reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_ack_after_reset", ack, 0);
    run_frame(16'h0F0F, 16'h1234, 0, 0);

    for (int n = 0; n < 8; n++) begin
      run_frame(16'($urandom), 16'($urandom), 0, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    chk("data_held", data, last_rx);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
